gfx_line: RTL and testbench

Bresenham line rasterizer for the gfx pipeline. It accepts one line command (endpoints plus color) and emits one framebuffer pixel per cycle, as x/y, linear framebuffer address and color, on a valid/ready stream. The stream feeds the framebuffer writer that issues AXI writes into SRAM, which the VGA scanout then reads. It is the command-driven replacement for the fixed test pattern generator upstream of the framebuffer writer.

---
 rtl/gfx_pkg.sv | 15 +
 rtl/gfx_line_if.sv | 27 ++
 rtl/gfx_line.sv | 109 ++++++++++
 tb/tb_gfx_line.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared types and framebuffer geometry for the gfx pipeline.
package gfx_pkg;
    // Framebuffer dimensions match the visible area of the VGA mode.
    localparam int FB_WIDTH       = 640;
    localparam int FB_HEIGHT      = 480;
    localparam int PIXEL_BITS     = 12;
    localparam int COORD_BITS     = 10;
    localparam int AXI_ADDR_WIDTH = 20;
    localparam int ERR_BITS       = COORD_BITS + 2;
    typedef logic [COORD_BITS-1:0]     coord_t;
    typedef logic [PIXEL_BITS-1:0]     color_t;
    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic signed [ERR_BITS-1:0] err_t;
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} gfx_line_state_t;
endpackage

// File: rtl/gfx_line_if.sv
// gfx_line_if: line command input and pixel stream output of the rasterizer.
interface gfx_line_if;
    import gfx_pkg::*;
    logic   start_valid;
    logic   start_ready;
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
    color_t color;
    logic   pix_valid;
    logic   pix_ready;
    coord_t pix_x;
    coord_t pix_y;
    addr_t  pix_addr;
    color_t pix_color;
    logic   busy;
    logic   done;
    modport master (
        output start_valid, x0, y0, x1, y1, color, pix_ready,
        input  start_ready, pix_valid, pix_x, pix_y, pix_addr, pix_color, busy, done
    );
    modport slave (
        input  start_valid, x0, y0, x1, y1, color, pix_ready,
        output start_ready, pix_valid, pix_x, pix_y, pix_addr, pix_color, busy, done
    );
endinterface

// File: rtl/gfx_line.sv
// gfx_line: Bresenham line rasterizer emitting one framebuffer pixel per step on a valid/ready stream.
module gfx_line
    import gfx_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    gfx_line_if.slave bus
);
    localparam coord_t X_LIM   = coord_t'(FB_WIDTH);
    localparam coord_t Y_LIM   = coord_t'(FB_HEIGHT);
    localparam coord_t C_ONE   = coord_t'(1);
    localparam addr_t  A_ONE   = addr_t'(1);
    localparam addr_t  A_ROW   = addr_t'(FB_WIDTH);
    localparam err_t   E_ZERO  = err_t'(0);

    gfx_line_state_t r_state, w_next;
    coord_t r_x0, r_y0, r_x1, r_y1, r_cur_x, r_cur_y;
    color_t r_color;
    err_t   r_err, r_dx, r_dy;
    logic   r_sx_neg, r_sy_neg;
    addr_t  r_addr;

    logic   w_in_range, w_step, w_last, w_step_x, w_step_y;
    coord_t w_adx, w_ady, w_nx, w_ny;
    err_t   w_e2, w_err;
    addr_t  w_ax, w_naddr;

    assign w_in_range = (r_cur_x < X_LIM) && (r_cur_y < Y_LIM);
    // Clipped pixels are never offered downstream, so they advance without a handshake.
    assign w_step     = (r_state == DRAW) && (bus.pix_ready || !w_in_range);
    assign w_last     = (r_cur_x == r_x1) && (r_cur_y == r_y1);
    assign w_adx      = (r_x1 >= r_x0) ? r_x1 - r_x0 : r_x0 - r_x1;
    assign w_ady      = (r_y1 >= r_y0) ? r_y1 - r_y0 : r_y0 - r_y1;
    assign w_e2       = r_err <<< 1;
    assign w_step_x   = w_e2 >= r_dy;
    assign w_step_y   = w_e2 <= r_dx;
    assign w_err      = r_err + (w_step_x ? r_dy : E_ZERO) + (w_step_y ? r_dx : E_ZERO);
    assign w_nx       = w_step_x ? (r_sx_neg ? r_cur_x - C_ONE : r_cur_x + C_ONE) : r_cur_x;
    assign w_ny       = w_step_y ? (r_sy_neg ? r_cur_y - C_ONE : r_cur_y + C_ONE) : r_cur_y;
    assign w_ax       = w_step_x ? (r_sx_neg ? r_addr - A_ONE : r_addr + A_ONE) : r_addr;
    assign w_naddr    = w_step_y ? (r_sy_neg ? w_ax - A_ROW : w_ax + A_ROW) : w_ax;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start_valid ? SETUP : IDLE;
            SETUP:   w_next = DRAW;
            DRAW:    w_next = (w_step && w_last) ? DONE : DRAW;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_color  <= '0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_err    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_addr   <= '0;
        end else begin
            if (r_state == IDLE && bus.start_valid) begin
                r_x0    <= bus.x0;
                r_y0    <= bus.y0;
                r_x1    <= bus.x1;
                r_y1    <= bus.y1;
                r_color <= bus.color;
            end
            if (r_state == SETUP) begin
                r_dx     <= err_t'(w_adx);
                r_dy     <= -err_t'(w_ady);
                r_err    <= err_t'(w_adx) - err_t'(w_ady);
                r_sx_neg <= r_x1 < r_x0;
                r_sy_neg <= r_y1 < r_y0;
                r_cur_x  <= r_x0;
                r_cur_y  <= r_y0;
                r_addr   <= addr_t'(r_y0) * A_ROW + addr_t'(r_x0);
            end
            if (w_step && !w_last) begin
                r_cur_x <= w_nx;
                r_cur_y <= w_ny;
                r_err   <= w_err;
                r_addr  <= w_naddr;
            end
        end
    end

    assign bus.start_ready = r_state == IDLE;
    assign bus.busy        = r_state != IDLE;
    assign bus.done        = r_state == DONE;
    assign bus.pix_valid   = (r_state == DRAW) && w_in_range;
    assign bus.pix_x       = r_cur_x;
    assign bus.pix_y       = r_cur_y;
    assign bus.pix_addr    = r_addr;
    assign bus.pix_color   = r_color;
endmodule

// File: tb/tb_gfx_line.sv
// tb_gfx_line: directed and randomized line commands checked against a plain-integer line model.
module tb_gfx_line;
    import gfx_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int q_x[$];
    int q_y[$];
    int model_len;
    bit model_first_in;

    gfx_line_if bus();
    gfx_line dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every point on the line in order, keeping only those inside the framebuffer.
    task automatic build_model(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        q_x.delete();
        q_y.delete();
        model_len = 0;
        dx = (bx > ax) ? bx - ax : ax - bx;
        dy = -((by > ay) ? by - ay : ay - by);
        sx = (bx >= ax) ? 1 : -1;
        sy = (by >= ay) ? 1 : -1;
        err = dx + dy;
        x = ax;
        y = ay;
        model_first_in = (ax < FB_WIDTH) && (ay < FB_HEIGHT);
        forever begin
            model_len++;
            if (x < FB_WIDTH && y < FB_HEIGHT) begin
                q_x.push_back(x);
                q_y.push_back(y);
            end
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_x", bus.pix_x, 0);
        chk("rst_y", bus.pix_y, 0);
        chk("rst_addr", bus.pix_addr, 0);
        chk("rst_color", bus.pix_color, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_start_ready", bus.start_ready, 1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input int col, input int mode);
        int cyc, idx, first_cyc, k;
        bit stalled, seen_done;
        logic [31:0] hx, hy, ha;
        build_model(ax, ay, bx, by);
        chk("idle_start_ready", bus.start_ready, 1);
        bus.start_valid = 1'b1;
        bus.x0 = coord_t'(ax);
        bus.y0 = coord_t'(ay);
        bus.x1 = coord_t'(bx);
        bus.y1 = coord_t'(by);
        bus.color = color_t'(col);
        tick();
        cyc = 1;
        bus.start_valid = 1'b0;
        chk("setup_busy", bus.busy, 1);
        chk("setup_start_ready", bus.start_ready, 0);
        chk("setup_valid", bus.pix_valid, 0);
        idx = 0;
        first_cyc = -1;
        k = 0;
        stalled = 0;
        seen_done = 0;
        hx = 0; hy = 0; ha = 0;
        while (!seen_done && cyc < 4000) begin
            tick();
            cyc++;
            if (bus.done) begin
                seen_done = 1;
                bus.start_valid = 1'b0;
            end else begin
                // stray commands while busy must be ignored
                bus.start_valid = 1'($urandom_range(0, 1));
                bus.x0 = coord_t'($urandom_range(0, 1023));
                bus.y0 = coord_t'($urandom_range(0, 1023));
                bus.x1 = coord_t'($urandom_range(0, 1023));
                bus.y1 = coord_t'($urandom_range(0, 1023));
                bus.color = color_t'($urandom_range(0, 4095));
                bus.pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
                k++;
                if (stalled) begin
                    chk("hold_valid", bus.pix_valid, 1);
                    chk("hold_x", bus.pix_x, hx);
                    chk("hold_y", bus.pix_y, hy);
                    chk("hold_addr", bus.pix_addr, ha);
                end
                if (bus.pix_valid) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    if (bus.pix_ready) begin
                        if (idx < q_x.size()) begin
                            chk("pix_x", bus.pix_x, q_x[idx]);
                            chk("pix_y", bus.pix_y, q_y[idx]);
                            chk("pix_addr", bus.pix_addr, q_y[idx] * FB_WIDTH + q_x[idx]);
                            chk("pix_color", bus.pix_color, col);
                        end else begin
                            chk("extra_pixel", idx, q_x.size());
                        end
                        idx++;
                    end
                end
                stalled = bus.pix_valid && !bus.pix_ready;
                hx = bus.pix_x;
                hy = bus.pix_y;
                ha = bus.pix_addr;
            end
        end
        bus.start_valid = 1'b0;
        bus.pix_ready = 1'b1;
        chk("done_seen", seen_done, 1);
        if (!seen_done) begin
            do_reset();
        end else begin
            chk("pixel_count", idx, q_x.size());
            if (mode == 0) chk("done_cycle", cyc, model_len + 2);
            if (model_first_in) chk("first_valid_cycle", first_cyc, 2);
            tick();
            chk("done_pulse_end", bus.done, 0);
            chk("next_start_ready", bus.start_ready, 1);
            chk("idle_busy", bus.busy, 0);
        end
    endtask

    initial begin
        int ax, ay, bx, by;
        bus.start_valid = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.color = '0;
        bus.pix_ready = 1'b1;
        tick();
        tick();
        do_reset();

        run_line(0, 0, 3, 0, 'hF00, 0);
        run_line(5, 5, 3, 0, 'h0A5, 0);
        run_line(0, 0, 4, 4, 'h123, 1);
        run_line(636, 10, 643, 10, 'h0F0, 0);
        run_line(7, 9, 7, 9, 'h777, 0);
        run_line(639, 479, 639, 479, 'hABC, 2);
        run_line(650, 5, 650, 5, 'h111, 0);

        // reset in the middle of a long line
        bus.start_valid = 1'b1;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = coord_t'(100); bus.y1 = '0;
        bus.color = color_t'('h5A5);
        bus.pix_ready = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        repeat (4) tick();
        chk("midline_valid", bus.pix_valid, 1);
        chk("midline_x", bus.pix_x, 3);
        do_reset();
        run_line(2, 3, 6, 1, 'h0FF, 0);

        for (int i = 0; i < 25; i++) begin
            ax = $urandom_range(0, 700);
            ay = $urandom_range(0, 520);
            bx = ax + int'($urandom_range(0, 80)) - 40;
            by = ay + int'($urandom_range(0, 80)) - 40;
            if (bx < 0) bx = 0;
            if (by < 0) by = 0;
            run_line(ax, ay, bx, by, $urandom_range(0, 4095), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
